// File: rtl/sram_rd_streamer.sv
// ============================================================================
// sram_rd_streamer
// ----------------------------------------------------------------------------
// Purpose:
//   Read-side consumer stage for the 1rw1r 32x256 SRAM macro. A single
//   (base, length) command is turned into a sequence of reads on the macro's
//   read-only port 1, and the returned words are delivered as a valid/ready
//   stream to the downstream PE array. A small output FIFO absorbs the
//   macro's fixed one-cycle read latency and any downstream backpressure.
//   Reads are only issued when the FIFO is guaranteed to have room for the
//   returning word, so no word is ever dropped or duplicated.
//
// Ports:
//   clk            in   single clock, also the SRAM port-1 clock
//   rst            in   asynchronous, active-high reset
//   start_i        in   one-cycle command pulse, sampled only in IDLE
//   base_addr_i    in   address of the first word to read
//   length_i       in   number of words to read (0 means no access)
//   addr_stride_i  in   address increment (only with SRAM_RD_STRIDE_EN)
//   sram_csb1_o    out  SRAM port-1 chip select, active low (registered)
//   sram_addr1_o   out  SRAM port-1 address (registered)
//   sram_dout1_i   in   SRAM port-1 read data
//   out_data_o     out  stream data, head of the output FIFO
//   out_valid_o    out  stream valid, FIFO not empty
//   out_ready_i    in   downstream ready
//   busy_o         out  high from an accepted start until done
//   done_o         out  one-cycle pulse after the last word is handshaken
//
// Configuration:
//   SRAM_RD_STRIDE_EN  when defined, adds addr_stride_i; the read address
//                      advances by the stride latched at start instead of 1.
// ============================================================================
module sram_rd_streamer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [LEN_WIDTH-1:0]  length_i,
`ifdef SRAM_RD_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0] addr_stride_i,
`endif
    output logic                  sram_csb1_o,
    output logic [ADDR_WIDTH-1:0] sram_addr1_o,
    input  logic [DATA_WIDTH-1:0] sram_dout1_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  busy_o,
    output logic                  done_o
);

    // Pointer width and occupancy-counter width (counter must hold DEPTH).
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = PW + 1;
    localparam int CW1 = CW + 1;
    localparam logic [CW:0] DEPTH_CMP = CW1'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   rdAddr_q, rdAddr_d;
    logic [LEN_WIDTH-1:0]    issueCnt_q, issueCnt_d;
    logic [LEN_WIDTH-1:0]    popCnt_q, popCnt_d;
    logic                    csb1_q, csb1_d;
    logic [ADDR_WIDTH-1:0]   addr1_q, addr1_d;
    logic                    done_q, done_d;

    logic [DATA_WIDTH-1:0]   fifoMem_q [FIFO_DEPTH];
    logic [PW-1:0]           wrPtr_q;
    logic [PW-1:0]           rdPtr_q;
    logic [CW-1:0]           fifoCount_q;

    logic                    inflight;
    logic                    fifoPush;
    logic                    fifoPop;
    logic                    fifoEmpty;
    logic                    fifoFull;
    logic                    creditOk;
    logic                    cmdAccept;
    logic [ADDR_WIDTH-1:0]   strideVal;

    // A read issued last cycle shows up as csb1 still low this cycle; its data
    // is on sram_dout1_i now and lands in the FIFO at the coming edge.
    assign inflight  = ~csb1_q;
    assign fifoPush  = inflight;
    assign fifoEmpty = (fifoCount_q == '0);
    assign fifoFull  = (fifoCount_q == CW'(FIFO_DEPTH));
    assign fifoPop   = out_valid_o & out_ready_i;

    // Credit check ignores a pop at the same edge on purpose: it keeps the
    // decision independent of out_ready_i and still sustains one word/cycle.
    assign creditOk  = (({1'b0, fifoCount_q} + {{CW{1'b0}}, inflight}) < DEPTH_CMP);

    assign cmdAccept = (state_q == IDLE) && start_i && (length_i != '0);

`ifdef SRAM_RD_STRIDE_EN
    logic [ADDR_WIDTH-1:0] stride_q;

    // Stride is captured together with the command so it cannot change mid-read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stride_q <= '0;
        end else if (cmdAccept) begin
            stride_q <= addr_stride_i;
        end
    end

    assign strideVal = stride_q;
`else
    assign strideVal = ADDR_WIDTH'(1);
`endif

    // Control state, read-side counters and the registered SRAM port pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rdAddr_q   <= '0;
            issueCnt_q <= '0;
            popCnt_q   <= '0;
            csb1_q     <= 1'b1;
            addr1_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdAddr_q   <= rdAddr_d;
            issueCnt_q <= issueCnt_d;
            popCnt_q   <= popCnt_d;
            csb1_q     <= csb1_d;
            addr1_q    <= addr1_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic: command capture, credit-gated issue and completion.
    always_comb begin
        state_d    = state_q;
        rdAddr_d   = rdAddr_q;
        issueCnt_d = issueCnt_q;
        popCnt_d   = popCnt_q;
        csb1_d     = 1'b1;
        addr1_d    = addr1_q;
        done_d     = 1'b0;

        if (fifoPop) begin
            popCnt_d = popCnt_q - LEN_WIDTH'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (length_i != '0) begin
                        rdAddr_d   = base_addr_i;
                        issueCnt_d = length_i;
                        popCnt_d   = length_i;
                        state_d    = ISSUE;
                    end else begin
                        // Empty command completes at once without touching the SRAM.
                        done_d = 1'b1;
                    end
                end
            end

            ISSUE: begin
                if ((issueCnt_q != '0) && creditOk) begin
                    csb1_d     = 1'b0;
                    addr1_d    = rdAddr_q;
                    rdAddr_d   = rdAddr_q + strideVal;
                    issueCnt_d = issueCnt_q - LEN_WIDTH'(1);
                    if (issueCnt_q == LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end

            DRAIN: begin
                // The last word can only be popped here: it reaches the FIFO
                // at least one edge after the final issue moved us to DRAIN.
                if (fifoPop && (popCnt_q == LEN_WIDTH'(1))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output FIFO. Push and pop may coincide even when full: the head being
    // popped is read before the edge that overwrites its slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifoMem_q[i] <= '0;
            end
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoCount_q <= '0;
        end else begin
            if (fifoPush) begin
                fifoMem_q[wrPtr_q] <= sram_dout1_i;
                wrPtr_q            <= wrPtr_q + PW'(1);
            end
            if (fifoPop) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            unique case ({fifoPush, fifoPop})
                2'b10:   fifoCount_q <= fifoCount_q + CW'(1);
                2'b01:   fifoCount_q <= fifoCount_q - CW'(1);
                default: fifoCount_q <= fifoCount_q;
            endcase
        end
    end

    // The credit rule must make an overflowing push impossible.
    fifoNoOverflow: assert property (@(posedge clk) disable iff (rst)
        !(fifoPush && !fifoPop && fifoFull));

    assign sram_csb1_o  = csb1_q;
    assign sram_addr1_o = addr1_q;
    assign out_data_o   = fifoMem_q[rdPtr_q];
    assign out_valid_o  = ~fifoEmpty;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;

endmodule

// File: tb/tb_sram_rd_streamer.sv
// ============================================================================
// tb_sram_rd_streamer
// ----------------------------------------------------------------------------
// Purpose:
//   Self-checking bench for sram_rd_streamer. A behavioural SRAM returns
//   mem[addr] while csb1 is low. Each accepted command is expanded into the
//   list of addresses and words it must produce; a monitor compares every
//   issued read and every handshaken word against those lists, checks the
//   read-credit rule and stability under backpressure.
//
// Configuration:
//   SRAM_RD_STRIDE_EN  when defined, drives addr_stride_i and runs the
//                      strided-read step.
// ============================================================================
module tb_sram_rd_streamer;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int LW    = 9;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] baseAddr;
    logic [LW-1:0] length;
    logic          sramCsb1;
    logic [AW-1:0] sramAddr1;
    logic [DW-1:0] sramDout1;
    logic [DW-1:0] outData;
    logic          outValid;
    logic          outReady;
    logic          busy;
    logic          done;
`ifdef SRAM_RD_STRIDE_EN
    logic [AW-1:0] addrStride;
`endif

    logic [DW-1:0] mem [256];

    logic [AW-1:0] expAddrQ [$];
    logic [DW-1:0] expDataQ [$];

    int   checks;
    int   errors;
    int   issued;
    int   popped;
    bit   stallDue;
    bit   prevHold;
    logic [DW-1:0] prevData;
    time  lastHsTime;
    time  t0;
    bit   modelBusy;
    bit   readyRandom;

    sram_rd_streamer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .LEN_WIDTH (LW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .base_addr_i  (baseAddr),
        .length_i     (length),
`ifdef SRAM_RD_STRIDE_EN
        .addr_stride_i(addrStride),
`endif
        .sram_csb1_o  (sramCsb1),
        .sram_addr1_o (sramAddr1),
        .sram_dout1_i (sramDout1),
        .out_data_o   (outData),
        .out_valid_o  (outValid),
        .out_ready_i  (outReady),
        .busy_o       (busy),
        .done_o       (done)
    );

    // The macro's registered address is the DUT's registered addr1, so the
    // data for a read issued at edge N is visible before edge N+1.
    assign sramDout1 = sramCsb1 ? 32'hDEAD_BEEF : mem[sramAddr1];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Downstream ready: held high, or 30% duty random when requested.
    initial begin
        outReady = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            outReady = readyRandom ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Stream/read monitor, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            issued   = 0;
            popped   = 0;
            stallDue = 1'b0;
            prevHold = 1'b0;
        end else begin
            if (stallDue) begin
                checkOutput("credit_stall", 32'(sramCsb1), 32'd1);
            end
            if (!sramCsb1) begin
                issued++;
                checkOutput("read_expected", 32'(expAddrQ.size() != 0), 32'd1);
                if (expAddrQ.size() != 0) begin
                    checkOutput("read_addr", 32'(sramAddr1), 32'(expAddrQ.pop_front()));
                end
            end
            checkOutput("no_overflow", 32'((issued - popped) <= DEPTH), 32'd1);
            stallDue = ((issued - popped) >= DEPTH);
            if (prevHold) begin
                checkOutput("hold_valid", 32'(outValid), 32'd1);
                checkOutput("hold_data", outData, prevData);
            end
            if (outValid && outReady) begin
                checkOutput("word_expected", 32'(expDataQ.size() != 0), 32'd1);
                if (expDataQ.size() != 0) begin
                    checkOutput("stream_data", outData, expDataQ.pop_front());
                end
                popped++;
                lastHsTime = $time;
            end
            prevHold = outValid && !outReady;
            prevData = outData;
        end
    end

    // Issue one command; the model queues its reads only if the DUT is idle.
    task automatic applyStimulus(input logic [AW-1:0] base, input int len,
                                 input logic [AW-1:0] stride);
        logic [AW-1:0] a;
        @(posedge clk);
        #2;
        baseAddr = base;
        length   = LW'(len);
`ifdef SRAM_RD_STRIDE_EN
        addrStride = stride;
`endif
        start = 1'b1;
        if (!modelBusy && len != 0) begin
            for (int i = 0; i < len; i++) begin
                a = AW'((int'(base) + i * int'(stride)) % 256);
                expAddrQ.push_back(a);
                expDataQ.push_back(mem[a]);
            end
            modelBusy = 1'b1;
        end
        @(posedge clk);
        #2;
        t0    = $time;
        start = 1'b0;
    endtask

    // Wait (bounded) for done; expLatency 0 skips the fixed-throughput check.
    task automatic waitDone(input int expLatency);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            if (done) break;
        end
        checkOutput("done_seen", 32'(done), 32'd1);
        checkOutput("done_after_last_hs", 32'($time - lastHsTime), 32'd11);
        if (expLatency != 0) begin
            checkOutput("done_latency", 32'($time - t0), 32'(expLatency));
        end
        checkOutput("busy_at_done", 32'(busy), 32'd0);
        checkOutput("all_words_out", 32'(expDataQ.size()), 32'd0);
        modelBusy = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int p0;
        logic [AW-1:0] rb;
        checks      = 0;
        errors      = 0;
        modelBusy   = 1'b0;
        readyRandom = 1'b0;
        lastHsTime  = 0;
        t0          = 0;
        start       = 1'b0;
        baseAddr    = '0;
        length      = '0;
`ifdef SRAM_RD_STRIDE_EN
        addrStride  = '0;
`endif
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'hA500_0000 + 32'(i);
        end
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        checkOutput("rst_csb1", 32'(sramCsb1), 32'd1);
        checkOutput("rst_addr1", 32'(sramAddr1), 32'd0);
        checkOutput("rst_valid", 32'(outValid), 32'd0);
        checkOutput("rst_data", outData, 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        $display("[TB] step: base 0x10 len 8, first-word latency");
        applyStimulus(8'h10, 8, 8'd1);
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        checkOutput("valid_edge0", 32'(outValid), 32'd0);
        @(posedge clk);
        #2;
        checkOutput("valid_edge1", 32'(outValid), 32'd0);
        checkOutput("csb1_edge1", 32'(sramCsb1), 32'd0);
        @(posedge clk);
        #2;
        checkOutput("valid_edge2", 32'(outValid), 32'd1);
        waitDone((8 + 2) * 10 + 4);

        $display("[TB] step: address wrap 0xFE len 4");
        applyStimulus(8'hFE, 4, 8'd1);
        waitDone((4 + 2) * 10 + 4);

        $display("[TB] step: len 64 with random backpressure");
        readyRandom = 1'b1;
        rb = AW'($urandom_range(0, 255));
        p0 = popped;
        applyStimulus(rb, 64, 8'd1);
        waitDone(0);
        checkOutput("words_64", 32'(popped - p0), 32'd64);
        readyRandom = 1'b0;

        $display("[TB] step: zero-length command");
        applyStimulus(8'h33, 0, 8'd1);
        checkOutput("len0_done", 32'(done), 32'd1);
        checkOutput("len0_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #2;
        checkOutput("len0_done_drop", 32'(done), 32'd0);
        repeat (4) @(posedge clk);

        $display("[TB] step: start while busy is ignored");
        p0 = popped;
        applyStimulus(8'h20, 6, 8'd1);
        applyStimulus(8'h80, 5, 8'd1);
        waitDone(0);
        repeat (10) @(posedge clk);
        #2;
        checkOutput("words_first_cmd", 32'(popped - p0), 32'd6);
        checkOutput("idle_after_ignored", 32'(busy), 32'd0);

        $display("[TB] step: reset in the middle of a 16-word read");
        p0 = popped;
        applyStimulus(8'h00, 16, 8'd1);
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #2;
            if (popped - p0 >= 3) break;
        end
        checkOutput("reached_word3", 32'(popped - p0 >= 3), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_csb1", 32'(sramCsb1), 32'd1);
        checkOutput("midrst_valid", 32'(outValid), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        expAddrQ.delete();
        expDataQ.delete();
        modelBusy = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        applyStimulus(8'h40, 2, 8'd1);
        waitDone((2 + 2) * 10 + 4);
        checkOutput("words_after_rst", 32'(popped), 32'd2);

        $display("[TB] step: random commands with random backpressure");
        for (int k = 0; k < 4; k++) begin
            readyRandom = ($urandom_range(0, 1) == 1);
            applyStimulus(AW'($urandom_range(0, 255)), $urandom_range(1, 40), 8'd1);
            waitDone(0);
        end
        readyRandom = 1'b0;

`ifdef SRAM_RD_STRIDE_EN
        $display("[TB] step: stride 0x40 len 5");
        applyStimulus(8'h00, 5, 8'h40);
        waitDone((5 + 2) * 10 + 4);
        $display("[TB] step: stride 0 re-reads one word");
        applyStimulus(8'h77, 3, 8'h00);
        waitDone((3 + 2) * 10 + 4);
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
